// File: rtl/fir_pkg.sv
// fir_pkg: sample widths shared by the FIR datapath blocks and their benches
package fir_pkg;
   localparam int FIR_IN_W  = 20;
   localparam int FIR_OUT_W = 8;
   localparam int DECIM_CW  = 4;
endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: sync FIFO (clk, rst_n, wr_valid/wr_data in, rd_ready in, rd_data/rd_valid/full out), head registered onto rd_data
module fir_out_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_valid,
   input  logic [W-1:0] wr_data,
   input  logic         rd_ready,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] rd, wr, rd_n, wr_n;
   logic pop, push;
   assign rd_valid = rd != wr;
   assign full = (rd[AW] != wr[AW]) && (rd[AW-1:0] == wr[AW-1:0]);
   assign pop = rd_valid & rd_ready;
   assign push = wr_valid & (~full | pop);
   assign rd_n = pop ? rd + 1'b1 : rd;
   assign wr_n = push ? wr + 1'b1 : wr;
   always_ff @(posedge clk)
      if (push) mem[wr[AW-1:0]] <= wr_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd      <= '0;
         wr      <= '0;
         rd_data <= '0;
      end else begin
         rd <= rd_n;
         wr <= wr_n;
         if (rd_n != wr_n) rd_data <= (rd_n == wr) ? wr_data : mem[rd_n[AW-1:0]];
      end
endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: decimate, round-shift and saturate filter samples into a ready/valid FIFO (CLK_Filter, rst_n, in_*, out_*, overflow, sat_flag, clr_flags)
module fir_out_requant
   import fir_pkg::*;
#(
   parameter int IN_W       = FIR_IN_W,
   parameter int OUT_W      = FIR_OUT_W,
   parameter int SHIFT      = 10,
   parameter int DECIM      = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             CLK_Filter,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             sat_flag,
   input  logic             clr_flags
);
   localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
   localparam logic [IN_W:0] MAXV = (IN_W+1)'((1 << OUT_W) - 1);
   logic [DECIM_CW-1:0] cnt;
   logic [IN_W:0] r;
   logic [OUT_W-1:0] q, s1_d, s2_d;
   logic keep, sat, s1_v, s2_v, full, ovf_set;
   assign r = ({1'b0, in_data} + HALF) >> SHIFT;
   assign sat = r > MAXV;
   assign q = sat ? '1 : r[OUT_W-1:0];
   assign keep = in_valid && cnt == '0;
   assign ovf_set = s2_v & full & ~(out_valid & out_ready);
   always_ff @(posedge CLK_Filter or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         s1_v     <= 1'b0;
         s1_d     <= '0;
         s2_v     <= 1'b0;
         s2_d     <= '0;
         sat_flag <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (in_valid) cnt <= (cnt == DECIM_CW'(DECIM-1)) ? '0 : cnt + 1'b1;
         s1_v <= keep;
         if (keep) s1_d <= q;
         s2_v <= s1_v;
         if (s1_v) s2_d <= s1_d;
         sat_flag <= (keep & sat) | (sat_flag & ~clr_flags);
         overflow <= ovf_set | (overflow & ~clr_flags);
      end
   fir_out_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (CLK_Filter),
      .rst_n    (rst_n),
      .wr_valid (s2_v),
      .wr_data  (s2_d),
      .rd_ready (out_ready),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .full     (full)
   );
endmodule
